// File: rtl/i2c_slave_core_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_core_if
// Bundles the pin-side and host-side signals of the I2C target engine so the
// core and its host see one connection.
//   enable      host -> core  0 = core ignores the bus and releases SDA
//   slave_addr  host -> core  own 7-bit address
//   scl_in      pad  -> core  SCL pin level (asynchronous)
//   sda_in      pad  -> core  SDA pin level (asynchronous)
//   tx_data     host -> core  byte returned on a master read
//   sda_oe      core -> pad   1 = pull SDA low, 0 = release
//   busy, rw, rx_data, rx_valid, tx_req, start_det, stop_det, rd_nack
//               core -> host  status, data and one-cycle strobes
// ----------------------------------------------------------------------------
interface i2c_slave_core_if;
    logic       enable;
    logic [6:0] slave_addr;
    logic       scl_in;
    logic       sda_in;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic       busy;
    logic       rw;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       start_det;
    logic       stop_det;
    logic       rd_nack;

    // The core's view: bus pins and host controls in, status and strobes out.
    modport slave (
        input  enable, slave_addr, scl_in, sda_in, tx_data,
        output sda_oe, busy, rw, rx_data, rx_valid, tx_req,
               start_det, stop_det, rd_nack
    );

    // The host/bus side: mirror of the core's view.
    modport master (
        output enable, slave_addr, scl_in, sda_in, tx_data,
        input  sda_oe, busy, rw, rx_data, rx_valid, tx_req,
               start_det, stop_det, rd_nack
    );
endinterface

// File: rtl/i2c_slave_core.sv
// ----------------------------------------------------------------------------
// i2c_slave_core
// I2C target engine. Oversamples SCL/SDA on aclk, detects START / repeated
// START / STOP, matches a 7-bit address, ACKs master writes (one rx_valid
// strobe per byte) and serves master reads from tx_data (tx_req strobe per
// byte). SDA is driven open-drain through sda_oe; SCL is never driven.
// Ports:
//   aclk     system clock, at least 16x the SCL frequency
//   aresetn  asynchronous active-low reset
//   bus      i2c_slave_core_if.slave (pins, host controls, status, strobes)
// ----------------------------------------------------------------------------
module i2c_slave_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    i2c_slave_core_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclSync, r_sdaSync;
    logic                   r_sclPrev, r_sdaPrev;

    state_t     r_state,    w_stateNext;
    logic [7:0] r_shift,    w_shiftNext;
    logic [3:0] r_bitCnt,   w_bitCntNext;
    logic       r_sdaOe,    w_sdaOeNext;
    logic       r_busy,     w_busyNext;
    logic       r_rw,       w_rwNext;
    logic [7:0] r_rxData,   w_rxDataNext;
    logic       r_rxValid,  w_rxValidNext;
    logic       r_startDet, w_startDetNext;
    logic       r_stopDet,  w_stopDetNext;
    logic       r_rdNack,   w_rdNackNext;
    logic       w_txReq;

    logic       w_scl, w_sda, w_sclRise, w_sclFall, w_start, w_stop;
    logic [3:0] w_bitCntInc;
    logic [7:0] w_byteIn;

    assign w_scl     = r_sclSync[SYNC_STAGES-1];
    assign w_sda     = r_sdaSync[SYNC_STAGES-1];
    assign w_sclRise =  w_scl & ~r_sclPrev;
    assign w_sclFall = ~w_scl &  r_sclPrev;
    // SDA may only move while SCL is low; a move while SCL stays high is a
    // bus condition. Both are ignored while the core is disabled.
    assign w_start   = bus.enable & w_scl & r_sclPrev & ~w_sda &  r_sdaPrev;
    assign w_stop    = bus.enable & w_scl & r_sclPrev &  w_sda & ~r_sdaPrev;
    assign w_bitCntInc = (r_bitCnt == 4'd8) ? 4'd8 : r_bitCnt + 4'd1;
    assign w_byteIn  = {r_shift[6:0], w_sda};

    // Synchronisers plus one history flop per line. They reset to the idle
    // bus level (high) so a freshly reset core never sees a phantom edge.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sclSync <= '1;
            r_sdaSync <= '1;
            r_sclPrev <= 1'b1;
            r_sdaPrev <= 1'b1;
        end else begin
            r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], bus.scl_in};
            r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], bus.sda_in};
            r_sclPrev <= w_scl;
            r_sdaPrev <= w_sda;
        end
    end

    // Protocol state and datapath registers. Reset releases SDA at once.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_sdaOe    <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_rxData   <= '0;
            r_rxValid  <= 1'b0;
            r_startDet <= 1'b0;
            r_stopDet  <= 1'b0;
            r_rdNack   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shift    <= w_shiftNext;
            r_bitCnt   <= w_bitCntNext;
            r_sdaOe    <= w_sdaOeNext;
            r_busy     <= w_busyNext;
            r_rw       <= w_rwNext;
            r_rxData   <= w_rxDataNext;
            r_rxValid  <= w_rxValidNext;
            r_startDet <= w_startDetNext;
            r_stopDet  <= w_stopDetNext;
            r_rdNack   <= w_rdNackNext;
        end
    end

    // Next-state logic. Priority: disable, then START, then STOP, then the
    // SCL edge handling of the current state. In the two ACK states sda_oe
    // itself marks the phase: the first fall asserts it, the second releases.
    always_comb begin
        w_stateNext    = r_state;
        w_shiftNext    = r_shift;
        w_bitCntNext   = r_bitCnt;
        w_sdaOeNext    = r_sdaOe;
        w_busyNext     = r_busy;
        w_rwNext       = r_rw;
        w_rxDataNext   = r_rxData;
        w_rxValidNext  = 1'b0;
        w_startDetNext = 1'b0;
        w_stopDetNext  = 1'b0;
        w_rdNackNext   = 1'b0;
        w_txReq        = 1'b0;

        if (!bus.enable) begin
            w_stateNext  = IDLE;
            w_sdaOeNext  = 1'b0;
            w_busyNext   = 1'b0;
            w_bitCntNext = '0;
        end else if (w_start) begin
            w_startDetNext = 1'b1;
            w_bitCntNext   = '0;
            w_sdaOeNext    = 1'b0;
            w_stateNext    = ADDR;
        end else if (w_stop) begin
            w_stopDetNext = 1'b1;
            w_sdaOeNext   = 1'b0;
            w_busyNext    = 1'b0;
            w_stateNext   = IDLE;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_sclRise) begin
                        w_shiftNext  = w_byteIn;
                        w_bitCntNext = w_bitCntInc;
                        if (r_bitCnt == 4'd7) begin
                            w_bitCntNext = '0;
                            if (w_byteIn[7:1] == bus.slave_addr && w_byteIn[7:1] != 7'h00) begin
                                w_busyNext  = 1'b1;
                                w_rwNext    = w_byteIn[0];
                                w_stateNext = ADDR_ACK;
                            end else begin
                                w_busyNext  = 1'b0;
                                w_stateNext = WAIT_STOP;
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    if (w_sclFall) begin
                        if (!r_sdaOe) begin
                            w_sdaOeNext = 1'b1;
                        end else begin
                            w_sdaOeNext  = 1'b0;
                            w_bitCntNext = '0;
                            if (r_state == ADDR_ACK && r_rw) begin
                                w_txReq     = 1'b1;
                                w_shiftNext = bus.tx_data;
                                w_sdaOeNext = ~bus.tx_data[7];
                                w_stateNext = RD_DATA;
                            end else begin
                                w_stateNext = WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (w_sclRise) begin
                        w_shiftNext  = w_byteIn;
                        w_bitCntNext = w_bitCntInc;
                        if (r_bitCnt == 4'd7) begin
                            w_rxDataNext  = w_byteIn;
                            w_rxValidNext = 1'b1;
                            w_bitCntNext  = '0;
                            w_stateNext   = WR_ACK;
                        end
                    end
                end
                RD_DATA: begin
                    if (w_sclRise) begin
                        w_bitCntNext = w_bitCntInc;
                    end else if (w_sclFall) begin
                        if (r_bitCnt == 4'd8) begin
                            w_sdaOeNext  = 1'b0;
                            w_bitCntNext = '0;
                            w_stateNext  = RD_ACK;
                        end else begin
                            w_sdaOeNext = ~r_shift[6];
                            w_shiftNext = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (w_sclRise) begin
                        if (w_sda) begin
                            w_rdNackNext = 1'b1;
                            w_sdaOeNext  = 1'b0;
                            w_stateNext  = WAIT_STOP;
                        end else begin
                            w_bitCntNext = 4'd1;
                        end
                    end else if (w_sclFall && r_bitCnt == 4'd1) begin
                        w_txReq      = 1'b1;
                        w_shiftNext  = bus.tx_data;
                        w_sdaOeNext  = ~bus.tx_data[7];
                        w_bitCntNext = '0;
                        w_stateNext  = RD_DATA;
                    end
                end
                WAIT_STOP: w_sdaOeNext = 1'b0;
                IDLE:      w_sdaOeNext = 1'b0;
                default:   w_stateNext = IDLE;
            endcase
        end
    end

    assign bus.sda_oe    = r_sdaOe;
    assign bus.busy      = r_busy;
    assign bus.rw        = r_rw;
    assign bus.rx_data   = r_rxData;
    assign bus.rx_valid  = r_rxValid;
    assign bus.tx_req    = w_txReq;
    assign bus.start_det = r_startDet;
    assign bus.stop_det  = r_stopDet;
    assign bus.rd_nack   = r_rdNack;

endmodule
